// File: rtl/aux_mem_march_driver_pkg.sv
// rtl/aux_mem_march_driver_pkg.sv - shared widths, op and state encodings for the aux memory march driver
//
// Purpose : common definitions imported by the interface, the compare unit and the top.
// Contents: DATA_WIDTH / ADDR_WIDTH defaults, march op encodings, FSM state encodings,
//           op normalisation helper (reserved op folds onto a plain read-compare).

package aux_mem_march_driver_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 8;

   typedef enum logic [1:0] {
      AUX_OP_W  = 2'b00,   // W(d)
      AUX_OP_R  = 2'b01,   // R(d)
      AUX_OP_RW = 2'b10    // R(d)W(~d)
   } aux_op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCESS = 3'd1,
      ST_WRBACK = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } aux_state_e;

   // 2'b11 is reserved and behaves as a read-compare element.
   function automatic aux_op_e aux_op_norm(input logic [1:0] op);
      case (op)
         2'b00:   return AUX_OP_W;
         2'b10:   return AUX_OP_RW;
         default: return AUX_OP_R;
      endcase
   endfunction

endpackage

// File: rtl/aux_mem_march_driver_if.sv
// rtl/aux_mem_march_driver_if.sv - auxiliary memory port bundle
//
// Purpose : groups the auxiliary memory port signals.
// Signals : mem_we, mem_addr, mem_wdata (initiator -> memory), mem_rdata (memory -> initiator).
// Modports: master = march driver side, slave = memory side.

interface aux_mem_march_driver_if
   import aux_mem_march_driver_pkg::*;
#(
   parameter int DW = DATA_WIDTH,
   parameter int AW = ADDR_WIDTH
);
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport master (output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
   modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/aux_mem_cmp.sv
// rtl/aux_mem_cmp.sv - expect-token delay line, read-data compare and sticky fail
//
// Purpose : every issued read launches a token (valid, addr, expected data) that
//           emerges RD_LAT cycles later, lined up with mem_rdata; a mismatch sets fail.
// Ports   : clk, rst (async, active-high), clr (accepted start), rd_issue/rd_addr/exp_data
//           (read presented on the bus this cycle), rdata (memory read data), fail (sticky).
// Option  : AUX_MEM_FAIL_LOG_EN adds fail_addr/fail_data (first miscompare) and err_cnt
//           (saturating miscompare count).

module aux_mem_cmp
   import aux_mem_march_driver_pkg::*;
#(
   parameter int DW     = DATA_WIDTH,
   parameter int AW     = ADDR_WIDTH,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          rd_issue,
   input  logic [DW-1:0] exp_data,
   input  logic [DW-1:0] rdata,
   output logic          fail
`ifdef AUX_MEM_FAIL_LOG_EN
   ,
   input  logic [AW-1:0] rd_addr,
   output logic [AW-1:0] fail_addr,
   output logic [DW-1:0] fail_data,
   output logic [AW:0]   err_cnt
`endif
);

   logic [RD_LAT-1:0] tok_v;
   logic [DW-1:0]     tok_exp [RD_LAT];
   logic              miscmp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tok_v <= '0;
         for (int i = 0; i < RD_LAT; i++) tok_exp[i] <= '0;
      end else begin
         tok_v[0]   <= rd_issue;
         tok_exp[0] <= exp_data;
         for (int i = 1; i < RD_LAT; i++) begin
            tok_v[i]   <= tok_v[i-1];
            tok_exp[i] <= tok_exp[i-1];
         end
      end
   end

   // In an R/W element the write-back shares this cycle; rdata still holds the pre-write value.
   assign miscmp = tok_v[RD_LAT-1] && (rdata != tok_exp[RD_LAT-1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         fail <= 1'b0;
      else if (clr)    fail <= 1'b0;
      else if (miscmp) fail <= 1'b1;
   end

`ifdef AUX_MEM_FAIL_LOG_EN
   logic [AW-1:0] tok_addr [RD_LAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) tok_addr[i] <= '0;
      end else begin
         tok_addr[0] <= rd_addr;
         for (int i = 1; i < RD_LAT; i++) tok_addr[i] <= tok_addr[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst || clr) begin
         fail_addr <= '0;
         fail_data <= '0;
         err_cnt   <= '0;
      end else if (miscmp) begin
         // fail is still low on the first miscompare of the element
         if (!fail) begin
            fail_addr <= tok_addr[RD_LAT-1];
            fail_data <= rdata;
         end
         if (err_cnt != '1) err_cnt <= err_cnt + (AW+1)'(1);
      end
   end
`endif

endmodule

// File: rtl/aux_mem_march_driver.sv
// rtl/aux_mem_march_driver.sv - march element initiator for the 8x256 auxiliary memory
//
// Purpose : runs one march element (W(d), R(d) or R(d)W(~d)) over [lo..hi], ascending or
//           descending, and reports pass/fail back to the PMBIST sequencer.
// Ports   : clk, rst (async, active-high); start/op/dir/addr_lo/addr_hi/pattern (element
//           request, sampled on an accepted start); mem (aux memory port, master modport);
//           busy, done (one-cycle pulse), fail (sticky miscompare).
// Option  : AUX_MEM_FAIL_LOG_EN adds fail_addr, fail_data and err_cnt.

module aux_mem_march_driver
   import aux_mem_march_driver_pkg::*;
#(
   parameter int DW     = DATA_WIDTH,
   parameter int AW     = ADDR_WIDTH,
   parameter int RD_LAT = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [1:0]                   op,
   input  logic                         dir,
   input  logic [AW-1:0]                addr_lo,
   input  logic [AW-1:0]                addr_hi,
   input  logic [DW-1:0]                pattern,
   aux_mem_march_driver_if.master       mem,
   output logic                         busy,
   output logic                         done,
   output logic                         fail
`ifdef AUX_MEM_FAIL_LOG_EN
   ,
   output logic [AW-1:0]                fail_addr,
   output logic [DW-1:0]                fail_data,
   output logic [AW:0]                  err_cnt
`endif
);

   aux_state_e    state, state_nxt;
   aux_op_e       op_q, op_nxt;
   logic          dir_q, dir_nxt;
   logic [DW-1:0] pat_q, pat_nxt;
   logic [AW-1:0] lo_q, lo_nxt, hi_q, hi_nxt, cur_q, cur_nxt;
   logic [AW-1:0] step_addr, addr_o_nxt;
   logic [DW-1:0] wd_nxt;
   logic          we_nxt, re_nxt, re_q, last, issue, start_acc;

   assign step_addr = dir_q ? cur_q - AW'(1) : cur_q + AW'(1);
   // Termination is decided before stepping, so the window never wraps past 0 or all-ones.
   assign last      = dir_q ? (cur_q == lo_q) : (cur_q == hi_q);

   always_comb begin
      state_nxt  = state;
      op_nxt     = op_q;
      dir_nxt    = dir_q;
      pat_nxt    = pat_q;
      lo_nxt     = lo_q;
      hi_nxt     = hi_q;
      cur_nxt    = cur_q;
      we_nxt     = 1'b0;
      re_nxt     = 1'b0;
      addr_o_nxt = mem.mem_addr;
      wd_nxt     = mem.mem_wdata;
      issue      = 1'b0;
      start_acc  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               op_nxt    = aux_op_norm(op);
               dir_nxt   = dir;
               pat_nxt   = pattern;
               lo_nxt    = (addr_lo > addr_hi) ? addr_hi : addr_lo;
               hi_nxt    = (addr_lo > addr_hi) ? addr_lo : addr_hi;
               cur_nxt   = dir ? hi_nxt : lo_nxt;
               issue     = 1'b1;
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (op_q == AUX_OP_RW) begin
               we_nxt     = 1'b1;
               addr_o_nxt = cur_q;
               wd_nxt     = ~pat_q;
               state_nxt  = ST_WRBACK;
            end else if (last) begin
               state_nxt = (op_q == AUX_OP_W) ? ST_DONE : ST_DRAIN;
            end else begin
               cur_nxt = step_addr;
               issue   = 1'b1;
            end
         end
         ST_WRBACK: begin
            if (last) begin
               state_nxt = ST_DRAIN;
            end else begin
               cur_nxt   = step_addr;
               issue     = 1'b1;
               state_nxt = ST_ACCESS;
            end
         end
         ST_DRAIN: state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase

      // Primary access of an ACCESS cycle: write d for W elements, read otherwise.
      if (issue) begin
         addr_o_nxt = cur_nxt;
         if (op_nxt == AUX_OP_W) begin
            we_nxt = 1'b1;
            wd_nxt = pat_nxt;
         end else begin
            re_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         op_q          <= AUX_OP_W;
         dir_q         <= 1'b0;
         pat_q         <= '0;
         lo_q          <= '0;
         hi_q          <= '0;
         cur_q         <= '0;
         re_q          <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state         <= state_nxt;
         op_q          <= op_nxt;
         dir_q         <= dir_nxt;
         pat_q         <= pat_nxt;
         lo_q          <= lo_nxt;
         hi_q          <= hi_nxt;
         cur_q         <= cur_nxt;
         re_q          <= re_nxt;
         mem.mem_we    <= we_nxt;
         mem.mem_addr  <= addr_o_nxt;
         mem.mem_wdata <= wd_nxt;
         busy          <= (state_nxt != ST_IDLE);
         done          <= (state_nxt == ST_DONE);
      end
   end

   aux_mem_cmp #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) u_cmp (
      .clk      (clk),
      .rst      (rst),
      .clr      (start_acc),
      .rd_issue (re_q),
      .exp_data (pat_q),
      .rdata    (mem.mem_rdata),
      .fail     (fail)
`ifdef AUX_MEM_FAIL_LOG_EN
      ,
      .rd_addr  (mem.mem_addr),
      .fail_addr(fail_addr),
      .fail_data(fail_data),
      .err_cnt  (err_cnt)
`endif
   );

endmodule

// File: tb/tb_aux_mem_march_driver.sv
// tb/tb_aux_mem_march_driver.sv - directed self-checking bench for aux_mem_march_driver

module tb_aux_mem_march_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] op = 2'b00;
   logic       dir = 1'b0;
   logic [7:0] addr_lo = '0, addr_hi = '0, pattern = '0;
   logic       busy, done, fail;
`ifdef AUX_MEM_FAIL_LOG_EN
   logic [7:0] fail_addr, fail_data;
   logic [8:0] err_cnt;
`endif

   aux_mem_march_driver_if #(.DW(8), .AW(8)) mif ();

   aux_mem_march_driver #(.DW(8), .AW(8), .RD_LAT(1)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .dir      (dir),
      .addr_lo  (addr_lo),
      .addr_hi  (addr_hi),
      .pattern  (pattern),
      .mem      (mif),
      .busy     (busy),
      .done     (done),
      .fail     (fail)
`ifdef AUX_MEM_FAIL_LOG_EN
      ,
      .fail_addr(fail_addr),
      .fail_data(fail_data),
      .err_cnt  (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   // 256x8 memory, registered read of the old contents, plus a backdoor write port.
   logic [7:0] mem_arr [256];
   logic       bd_we = 1'b0;
   logic [7:0] bd_addr = '0, bd_data = '0;

   always @(posedge clk) begin
      mif.mem_rdata <= mem_arr[mif.mem_addr];
      if (mif.mem_we)  mem_arr[mif.mem_addr] <= mif.mem_wdata;
      else if (bd_we)  mem_arr[bd_addr] <= bd_data;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   int         lat, n_done, n_we;
   logic       tr_we [$];
   logic [7:0] tr_addr [$];
   logic [7:0] tr_wd [$];

   // Cycle 1 is the first cycle after the start edge; lat is the cycle done is seen in.
   task automatic run_elem(input logic [1:0] o, input logic d, input logic [7:0] lo,
                           input logic [7:0] hi, input logic [7:0] pat, input int start2_at);
      @(negedge clk);
      op = o; dir = d; addr_lo = lo; addr_hi = hi; pattern = pat; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tr_we.delete(); tr_addr.delete(); tr_wd.delete();
      lat = -1; n_done = 0; n_we = 0;
      for (int c = 1; c <= 1200; c++) begin
         if (busy && !done) begin
            tr_we.push_back(mif.mem_we);
            tr_addr.push_back(mif.mem_addr);
            tr_wd.push_back(mif.mem_wdata);
            if (mif.mem_we) n_we++;
         end
         if (done) begin
            n_done++;
            if (lat < 0) lat = c;
         end
         if (lat >= 0 && c >= lat + 3) break;
         start = (c == start2_at);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      int bad;
      int found;
      int dcnt;

      // reset state
      @(negedge clk);
      check("rst_we", mif.mem_we, 0);
      check("rst_addr", mif.mem_addr, 0);
      check("rst_wdata", mif.mem_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_fail", fail, 0);
      rst = 1'b0;

      // W(0x55) ascending over the full window
      run_elem(2'b00, 1'b0, 8'h00, 8'hFF, 8'h55, -1);
      check("w_len", tr_addr.size(), 256);
      check("w_nwe", n_we, 256);
      bad = 0;
      for (int i = 0; i < tr_addr.size() && i < 256; i++)
         if (tr_addr[i] !== 8'(i) || tr_we[i] !== 1'b1 || tr_wd[i] !== 8'h55) bad++;
      check("w_seq", bad, 0);
      check("w_lat", lat, 257);
      check("w_ndone", n_done, 1);
      check("w_busy_after", busy, 0);
      check("w_fail", fail, 0);
      check("w_mem80", mem_arr[8'h80], 8'h55);

      // R(0x55) descending over the full window
      run_elem(2'b01, 1'b1, 8'h00, 8'hFF, 8'h55, -1);
      check("rd_nwe", n_we, 0);
      bad = 0;
      for (int i = 0; i < tr_addr.size() && i < 256; i++)
         if (tr_addr[i] !== 8'(255 - i)) bad++;
      check("rd_seq", bad, 0);
      check("rd_len", tr_addr.size(), 257);
      check("rd_lat", lat, 258);
      check("rd_ndone", n_done, 1);
      check("rd_fail", fail, 0);

      // miscompare at 0x3C, window given with swapped bounds
      bd_write(8'h3C, 8'h54);
      run_elem(2'b01, 1'b0, 8'h40, 8'h30, 8'h55, -1);
      check("mc_first", tr_addr.size() > 0 ? tr_addr[0] : 8'hxx, 8'h30);
      check("mc_len", tr_addr.size(), 18);
      check("mc_lat", lat, 19);
      check("mc_fail", fail, 1);
`ifdef AUX_MEM_FAIL_LOG_EN
      check("mc_faddr", fail_addr, 8'h3C);
      check("mc_fdata", fail_data, 8'h54);
      check("mc_errcnt", err_cnt, 1);
`endif

      // R(0xAA)W(0x55) ascending over 0x10..0x12
      bd_write(8'h10, 8'hAA);
      bd_write(8'h11, 8'hAA);
      bd_write(8'h12, 8'hAA);
      run_elem(2'b10, 1'b0, 8'h10, 8'h12, 8'hAA, -1);
      check("rw_len", tr_addr.size(), 7);
      bad = 0;
      for (int i = 0; i < 6 && i < tr_addr.size(); i++) begin
         if (tr_addr[i] !== 8'(8'h10 + i / 2)) bad++;
         if (tr_we[i] !== 1'(i % 2)) bad++;
         if ((i % 2) == 1 && tr_wd[i] !== 8'h55) bad++;
      end
      check("rw_seq", bad, 0);
      check("rw_lat", lat, 8);
      check("rw_fail", fail, 0);
      check("rw_mem12", mem_arr[8'h12], 8'h55);

      // reserved op behaves as R(0x55); the written-back data must compare clean
      run_elem(2'b11, 1'b0, 8'h10, 8'h12, 8'h55, -1);
      check("rsv_nwe", n_we, 0);
      check("rsv_fail", fail, 0);
      check("rsv_lat", lat, 5);

      // single-address window with a second start while busy
      run_elem(2'b01, 1'b0, 8'h20, 8'h20, 8'h55, 2);
      check("one_len", tr_addr.size(), 2);
      check("one_addr", tr_addr.size() > 0 ? tr_addr[0] : 8'hxx, 8'h20);
      check("one_ndone", n_done, 1);
      check("one_lat", lat, 3);
      check("one_busy_after", busy, 0);

      // asynchronous reset mid-element during the write-back at 0x80
      @(negedge clk);
      op = 2'b10; dir = 1'b0; addr_lo = 8'h00; addr_hi = 8'hFF; pattern = 8'h55; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 1000; c++) begin
         if (mif.mem_we && mif.mem_addr == 8'h80) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      check("ar_found", found, 1);
      check("ar_fail_pre", fail, 1);
      #2 rst = 1'b1;
      #1;
      check("ar_we", mif.mem_we, 0);
      check("ar_busy", busy, 0);
      check("ar_fail", fail, 0);
      check("ar_addr", mif.mem_addr, 0);
      dcnt = 0;
      @(negedge clk);
      if (done) dcnt++;
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("ar_nodone", dcnt, 0);

      // normal element after the abort
      run_elem(2'b00, 1'b0, 8'h05, 8'h07, 8'h0F, -1);
      check("post_first", tr_addr.size() > 0 ? tr_addr[0] : 8'hxx, 8'h05);
      check("post_nwe", n_we, 3);
      check("post_lat", lat, 4);
      check("post_ndone", n_done, 1);
      check("post_fail", fail, 0);
      check("post_mem06", mem_arr[8'h06], 8'h0F);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
